// File: rtl/hr_pkg.sv
// Shared definitions for the heart-rate arrhythmia datapath: session FSM
// states, final-analysis verdict codes and default session constants.
package hr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_WAIT_FIRST = 3'd2,
        ST_MEASURE    = 3'd3,
        ST_ANALYZE    = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } hr_state_t;

    localparam logic [1:0] HR_NORMAL = 2'b00;
    localparam logic [1:0] HR_BRADY  = 2'b01;
    localparam logic [1:0] HR_TACHY  = 2'b10;
    localparam logic [1:0] HR_IRREG  = 2'b11;

    localparam int HR_N_BEATS    = 16;
    localparam int HR_TIMEOUT_MS = 3000;
    localparam int HR_TMO_W      = 12;
    localparam int HR_BEAT_W     = 8;

endpackage

// File: rtl/hr_timeout_counter.sv
// Millisecond inactivity counter. Counts tick_i strobes since the last clear
// and flags expire_o on the tick that would make the count reach LIMIT.
// A clear in the same cycle as that tick wins, so no expiry is reported.
module hr_timeout_counter #(
    parameter int LIMIT = 3000,
    parameter int CNT_W = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear dominates, otherwise count ticks and park at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = tick_i && !clr_i && (cnt_q == LAST);

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hr_session_sequencer.sv
// Session controller for the heart-rate arrhythmia datapath. Arms the
// interval detector, counts N_BEATS measured intervals, hands off to the
// final analysis block, latches its verdict, and reports asystole / abort.
module hr_session_sequencer
    import hr_pkg::*;
#(
    parameter int N_BEATS    = HR_N_BEATS,
    parameter int TIMEOUT_MS = HR_TIMEOUT_MS,
    parameter int TMO_W      = HR_TMO_W,
    parameter int BEAT_W     = HR_BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              tick_ms,
    input  logic              beat_valid,
    input  logic              live_irreg,
    input  logic              final_done,
    input  logic [1:0]        final_code,
    output logic              div_en,
    output logic              intv_clr,
    output logic              intv_en,
    output logic              live_en,
    output logic              final_start,
    output logic              busy,
    output logic              done,
    output logic              err_asystole,
    output logic [1:0]        result,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic [BEAT_W-1:0] irreg_cnt
);

    localparam logic [BEAT_W-1:0] N_LAST = BEAT_W'(N_BEATS);

    hr_state_t         state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0] irreg_cnt_q, irreg_cnt_d;
    logic [BEAT_W-1:0] beat_inc;
    logic [1:0]        result_q, result_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic div_en_q, intv_clr_q, intv_en_q, live_en_q, final_start_q, busy_q;
    logic div_en_d, intv_clr_d, intv_en_d, live_en_d, final_start_d, busy_d;

    logic tmo_clr, tmo_tick, tmo_expire;

    // The reference beat restarts the window just like a counted beat, and
    // arming clears it so WAIT_FIRST starts from zero.
    assign tmo_clr  = beat_valid || (state_q == ST_ARM);
    assign tmo_tick = tick_ms && ((state_q == ST_WAIT_FIRST) || (state_q == ST_MEASURE));

    hr_timeout_counter #(
        .LIMIT (TIMEOUT_MS),
        .CNT_W (TMO_W)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr),
        .tick_i   (tmo_tick),
        .expire_o (tmo_expire)
    );

    assign beat_inc = beat_cnt_q + 1'b1;

    // Next-state and session bookkeeping; abort overrides every other event.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        irreg_cnt_d = irreg_cnt_q;
        result_d    = result_q;
        done_d      = done_q;
        err_d       = err_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            beat_cnt_d  = '0;
            irreg_cnt_d = '0;
            result_d    = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_d     = ST_ARM;
                        beat_cnt_d  = '0;
                        irreg_cnt_d = '0;
                        result_d    = '0;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                    end
                end
                ST_ARM: begin
                    state_d = ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    if (beat_valid) begin
                        state_d = ST_MEASURE;
                    end else if (tmo_expire) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (beat_valid) begin
                        beat_cnt_d = beat_inc;
                        if (live_irreg && (irreg_cnt_q != '1)) begin
                            irreg_cnt_d = irreg_cnt_q + 1'b1;
                        end
                        if (beat_inc == N_LAST) begin
                            state_d = ST_ANALYZE;
                        end
                    end else if (tmo_expire) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
                ST_ANALYZE: begin
                    if (final_done) begin
                        state_d  = ST_DONE;
                        result_d = final_code;
                        done_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        div_en_d      = (state_d == ST_WAIT_FIRST) || (state_d == ST_MEASURE) ||
                        (state_d == ST_ANALYZE);
        intv_en_d     = div_en_d;
        busy_d        = div_en_d || (state_d == ST_ARM);
        live_en_d     = (state_d == ST_MEASURE);
        intv_clr_d    = (state_d == ST_ARM);
        final_start_d = (state_d == ST_ANALYZE) && (state_q != ST_ANALYZE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            irreg_cnt_q   <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            div_en_q      <= 1'b0;
            intv_clr_q    <= 1'b0;
            intv_en_q     <= 1'b0;
            live_en_q     <= 1'b0;
            final_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            irreg_cnt_q   <= irreg_cnt_d;
            result_q      <= result_d;
            done_q        <= done_d;
            err_q         <= err_d;
            div_en_q      <= div_en_d;
            intv_clr_q    <= intv_clr_d;
            intv_en_q     <= intv_en_d;
            live_en_q     <= live_en_d;
            final_start_q <= final_start_d;
            busy_q        <= busy_d;
        end
    end

    assign div_en       = div_en_q;
    assign intv_clr     = intv_clr_q;
    assign intv_en      = intv_en_q;
    assign live_en      = live_en_q;
    assign final_start  = final_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_asystole = err_q;
    assign result       = result_q;
    assign beat_cnt     = beat_cnt_q;
    assign irreg_cnt    = irreg_cnt_q;

endmodule

// File: tb/tb_hr_session_sequencer.sv
// Scoreboard bench for hr_session_sequencer. Each session is described by a
// schedule (ticks before every beat, tick coincidence, irregular flags,
// verdict); a session-level model derives the outcome and queues it, and a
// monitor compares it when done or err_asystole rises.
module tb_hr_session_sequencer;

    localparam int NB  = 4;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, tick_ms, beat_valid, live_irreg, final_done;
    logic [1:0] final_code;
    logic       div_en, intv_clr, intv_en, live_en, final_start, busy, done, err_asystole;
    logic [1:0] result;
    logic [7:0] beat_cnt, irreg_cnt;

    hr_session_sequencer #(
        .N_BEATS    (NB),
        .TIMEOUT_MS (TMO),
        .TMO_W      (12),
        .BEAT_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .tick_ms      (tick_ms),
        .beat_valid   (beat_valid),
        .live_irreg   (live_irreg),
        .final_done   (final_done),
        .final_code   (final_code),
        .div_en       (div_en),
        .intv_clr     (intv_clr),
        .intv_en      (intv_en),
        .live_en      (live_en),
        .final_start  (final_start),
        .busy         (busy),
        .done         (done),
        .err_asystole (err_asystole),
        .result       (result),
        .beat_cnt     (beat_cnt),
        .irreg_cnt    (irreg_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] res;
        int         beats;
        int         irr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fs_cnt = 0;

    // Session schedule: interval 0 precedes the reference beat.
    int         c_arr  [NB+1];
    bit         co_arr [NB+1];
    bit         irr_arr[NB+1];
    logic [1:0] code_s;
    int         dly_s;
    bit         exp_err;
    int         err_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_asystole, 0);
        chk({tag, "_div_en"}, div_en, 0);
        chk({tag, "_intv_en"}, intv_en, 0);
        chk({tag, "_intv_clr"}, intv_clr, 0);
        chk({tag, "_live_en"}, live_en, 0);
        chk({tag, "_final_start"}, final_start, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_beat_cnt"}, beat_cnt, 0);
        chk({tag, "_irreg_cnt"}, irreg_cnt, 0);
    endtask

    task automatic set_sched(input int c, input logic [1:0] code, input int dly);
        for (int i = 0; i <= NB; i++) begin
            c_arr[i]   = c;
            co_arr[i]  = 1'b0;
            irr_arr[i] = 1'b0;
        end
        code_s = code;
        dly_s  = dly;
    endtask

    task automatic gen_random();
        for (int i = 0; i <= NB; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 80)      c_arr[i] = $urandom_range(0, 8);
            else if (r < 92) c_arr[i] = TMO - 1;
            else             c_arr[i] = TMO;
            co_arr[i]  = 1'($urandom_range(0, 1));
            irr_arr[i] = 1'($urandom_range(0, 1));
        end
        code_s = 2'($urandom_range(0, 3));
        dly_s  = $urandom_range(0, 3);
    endtask

    // A beat preceded by TMO or more counted ticks never arrives in time;
    // only beats after the reference are measured.
    task automatic model_push();
        exp_t e;
        int   last;
        exp_err = 1'b0;
        err_idx = -1;
        for (int i = 0; i <= NB; i++) begin
            if (c_arr[i] >= TMO) begin
                exp_err = 1'b1;
                err_idx = i;
                break;
            end
        end
        last     = exp_err ? err_idx - 1 : NB;
        e.is_err = exp_err;
        e.res    = exp_err ? 2'b00 : code_s;
        e.beats  = (last > 0) ? last : 0;
        e.irr    = 0;
        for (int i = 1; i <= last; i++) e.irr += irr_arr[i];
        sb_q.push_back(e);
    endtask

    task automatic play(input bit stop_in_analyze);
        bit seen;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        for (int i = 0; i <= NB; i++) begin
            if (c_arr[i] == 0) cyc();
            for (int k = 0; k < c_arr[i]; k++) begin
                tick_ms = 1'b1;
                cyc();
                tick_ms = 1'b0;
                if (k >= TMO - 2 && k <= TMO - 1) chk("asys_timing", err_asystole, (k == TMO - 1));
                cyc();
            end
            if (exp_err && i == err_idx) begin
                repeat (3) cyc();
                return;
            end
            beat_valid = 1'b1;
            live_irreg = irr_arr[i];
            tick_ms    = co_arr[i];
            start      = ($urandom_range(0, 3) == 0);
            cyc();
            beat_valid = 1'b0;
            live_irreg = 1'b0;
            tick_ms    = 1'b0;
            start      = 1'b0;
            chk("no_err_after_beat", err_asystole, 0);
        end
        seen = 1'b0;
        for (int w = 0; w < 8; w++) begin
            if (final_start) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        chk("final_start_seen", seen, 1);
        if (!seen || stop_in_analyze) return;
        for (int d = 0; d < dly_s; d++) begin
            beat_valid = 1'($urandom_range(0, 1));
            cyc();
            beat_valid = 1'b0;
        end
        final_done = 1'b1;
        final_code = code_s;
        cyc();
        final_done = 1'b0;
        final_code = 2'b00;
        cyc();
        cyc();
    endtask

    // Monitor: count final_start pulses per session, score each completion.
    initial begin
        logic done_prev, err_prev;
        exp_t e;
        done_prev = 1'b0;
        err_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (intv_clr) fs_cnt = 0;
            if (final_start) fs_cnt++;
            if ((done && !done_prev) || (err_asystole && !err_prev)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: done=%0b err=%0b appeared, required no event", done, err_asystole);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_err", err_asystole, e.is_err);
                    chk("sb_done", done, !e.is_err);
                    chk("sb_beat_cnt", beat_cnt, e.beats);
                    chk("sb_irreg_cnt", irreg_cnt, e.irr);
                    chk("sb_result", result, e.res);
                    chk("sb_final_start_cnt", fs_cnt, e.is_err ? 0 : 1);
                    chk("sb_busy", busy, 0);
                    chk("sb_div_en", div_en, 0);
                end
            end
            done_prev = done;
            err_prev  = err_asystole;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        tick_ms    = 1'b0;
        beat_valid = 1'b0;
        live_irreg = 1'b0;
        final_done = 1'b0;
        final_code = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Normal session, verdict normal, final_done three cycles after start pulse.
        set_sched(50, 2'b00, 3);
        model_push();
        play(1'b0);

        // Irregular flags on measured beats 2 and 4 (reference flag ignored).
        set_sched(5, 2'b11, 1);
        irr_arr[0] = 1'b1;
        irr_arr[2] = 1'b1;
        irr_arr[4] = 1'b1;
        model_push();
        play(1'b0);

        // Asystole after the reference beat.
        set_sched(3, 2'b01, 0);
        c_arr[1] = TMO;
        model_push();
        play(1'b0);

        // Beat coincident with the final tick wins; final_done in entry cycle.
        set_sched(4, 2'b10, 0);
        c_arr[1]  = TMO - 1;
        co_arr[1] = 1'b1;
        c_arr[3]  = TMO - 1;
        co_arr[3] = 1'b1;
        model_push();
        play(1'b0);

        // Abort mid-MEASURE coincident with a beat.
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        for (int b = 0; b < 3; b++) begin
            beat_valid = 1'b1;
            cyc();
            beat_valid = 1'b0;
            cyc();
        end
        chk("pre_abort_beat_cnt", beat_cnt, 2);
        chk("pre_abort_live_en", live_en, 1);
        abort      = 1'b1;
        beat_valid = 1'b1;
        cyc();
        abort      = 1'b0;
        beat_valid = 1'b0;
        check_all_zero("abort");
        final_done = 1'b1;
        final_code = 2'b11;
        cyc();
        final_done = 1'b0;
        final_code = 2'b00;
        cyc();
        check_all_zero("late_done");
        set_sched(7, 2'b00, 2);
        model_push();
        play(1'b0);

        // Asynchronous reset while in ANALYZE, then a full session.
        set_sched(6, 2'b10, 0);
        play(1'b1);
        chk("pre_rst_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        @(negedge clk);
        rst = 1'b0;
        cyc();
        set_sched(6, 2'b01, 2);
        irr_arr[3] = 1'b1;
        model_push();
        play(1'b0);

        // Randomized sessions.
        repeat (20) begin
            gen_random();
            model_push();
            play(1'b0);
        end

        repeat (5) cyc();
        chk("sb_queue_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hr_session_sequencer.md
Name: hr_session_sequencer

Overview:
- Top-level controller for the heart-rate arrhythmia datapath. Sequences one measurement session: clock-divider enable, interval-detection clear and enable, and live-comparator gating.
- Counts N_BEATS valid intervals, then hands off to the final-analysis comparator via a start/done handshake, latches its verdict and reports status.
- Detects asystole (no beat within TIMEOUT_MS) and user abort.

Parameters:
- N_BEATS, 16, number of intervals measured per session (2..255)
- TIMEOUT_MS, 3000, ms ticks without a beat before asystole error
- TMO_W, 12, width of timeout counter (must hold TIMEOUT_MS)
- BEAT_W, 8, width of beat and irregular counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle session start request
- abort  in  1  single-cycle abort request
- tick_ms  in  1  1 ms strobe from clock divider
- beat_valid  in  1  interval-detection pulse: new R-R interval available
- live_irreg  in  1  live comparator flag, qualified by beat_valid
- final_done  in  1  final analysis complete, single-cycle pulse
- final_code  in  2  final verdict, valid with final_done: 00 normal, 01 brady, 10 tachy, 11 irregular
- div_en  out  1  clock-divider enable
- intv_clr  out  1  interval-detection synchronous clear
- intv_en  out  1  interval-detection enable
- live_en  out  1  live comparator enable
- final_start  out  1  single-cycle start pulse to final analysis
- busy  out  1  session in progress
- done  out  1  result valid; level, held until next start/abort
- err_asystole  out  1  timeout error; level
- result  out  2  latched final_code
- beat_cnt  out  BEAT_W  intervals counted this session
- irreg_cnt  out  BEAT_W  live irregular flags this session, saturating

Behaviour:
- Reset: state IDLE. All outputs 0, all counters 0.
- States: IDLE, ARM, WAIT_FIRST, MEASURE, ANALYZE, DONE, ERROR. All outputs are registered.
- IDLE/DONE/ERROR + start -> ARM. In ARM: counters, result, done and err are cleared; intv_clr=1 for exactly one cycle. start in any other state is ignored.
- ARM -> WAIT_FIRST unconditionally, after 1 cycle.
- div_en=1 and intv_en=1 in WAIT_FIRST, MEASURE and ANALYZE.
- busy=1 in ARM, WAIT_FIRST, MEASURE and ANALYZE.
- WAIT_FIRST: the first beat_valid only establishes the reference beat. It is not counted, and the state moves to MEASURE.
- live_en=1 in MEASURE only.
- MEASURE: each beat_valid increments beat_cnt. If live_irreg is also high that cycle, irreg_cnt increments, saturating at all-ones. When beat_cnt reaches N_BEATS on that increment -> ANALYZE.
- Timeout counter:
  - Cleared on entry to WAIT_FIRST and on every beat_valid.
  - Increments on tick_ms in WAIT_FIRST and MEASURE.
  - When it reaches TIMEOUT_MS -> ERROR with err_asystole=1.
  - If beat_valid and the final tick arrive in the same cycle, the beat wins: counter clears, no error.
- ANALYZE:
  - final_start pulses 1 cycle on entry.
  - Wait for final_done; latch final_code into result; -> DONE with done=1.
  - final_done arriving in the entry cycle is accepted.
  - No timeout applies in ANALYZE.
- DONE/ERROR: div_en, intv_en and live_en are 0. beat_cnt, irreg_cnt and result hold for readout.
- abort in any non-IDLE state:
  - -> IDLE next cycle. All enables, busy, done and err are 0; counters are cleared.
  - abort has priority over start, beat_valid, final_done and timeout in the same cycle.
  - A late final_done arriving in IDLE is ignored.
- beat_valid and final_done outside their consuming states are ignored.
- Asynchronous rst mid-session: immediate return to the reset values above. No partial result survives.

Decomposition:
- Shared package hr_pkg holds:
  - state enum (hr_state_t)
  - verdict codes (HR_NORMAL, HR_BRADY, HR_TACHY, HR_IRREG)
  - default N_BEATS and TIMEOUT_MS constants, reused by interval detection and the comparators
- One sub-module: hr_timeout_counter (clear, tick, expire), so it can be reused by interval detection.
- The FSM and beat counters stay in this module.

Test Plan:
- Normal session, N_BEATS=4: start, 5 beat_valid 800 ms apart with live_irreg=0, final_done with code 00 three cycles after final_start -> beat_cnt=4, irreg_cnt=0, final_start exactly once, done=1, result=00, busy=0.
- Irregular count: N_BEATS=4; live_irreg high on beats 2 and 4 after the reference, final_code=11 -> irreg_cnt=2, result=11.
- Asystole: TIMEOUT_MS=100; start, one reference beat, then no beats for 100 ticks -> err_asystole=1 on the cycle after the 100th tick, final_start never asserted.
- Timeout race: beat_valid coincident with the 100th tick -> no error; counter restarts and session continues.
- Abort mid-MEASURE coincident with beat_valid -> IDLE next cycle, beat_cnt=0, all enables 0. A late final_done is ignored; start then begins a clean session.
- Async rst asserted in ANALYZE between clock edges -> outputs 0 immediately. start after release yields a full normal session.
